// File: rtl/wbank_pkg.sv
// Shared types and width helpers for the runtime-loadable weight bank.
// Holds the stream FSM state enum, the default word width and width functions.
package wbank_pkg;

    localparam int DATA_WIDTH_DEF = 16;

    typedef enum logic {
        ST_IDLE,
        ST_STREAM
    } state_e;

    // Channel select is at least one bit wide even for a single channel.
    function automatic int ch_w_f(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int idx_w_f(input int nw);
        return $clog2(nw + 1);
    endfunction

endpackage

// File: rtl/wbank_regfile.sv
// Weight/bias storage: synchronous write port and a registered read port.
// Ports: clk, rst, we/wch/widx/wdata write; re/rch/ridx read -> rdata
// (held when re=0). With WBANK_PARITY_EN each word keeps an even-parity bit
// and rerr flags a parity mismatch on the word held in rdata.
module wbank_regfile
    import wbank_pkg::*;
#(
    parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
    parameter int NUM_WEIGHTS = 16,
    parameter int NUM_NEURONS = 4,
    parameter int CH_W        = ch_w_f(NUM_NEURONS),
    parameter int IDX_W       = idx_w_f(NUM_WEIGHTS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [CH_W-1:0]       wch,
    input  logic [IDX_W-1:0]      widx,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [CH_W-1:0]       rch,
    input  logic [IDX_W-1:0]      ridx,
`ifdef WBANK_PARITY_EN
    output logic                  rerr,
`endif
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem_q [NUM_NEURONS][NUM_WEIGHTS+1];
    logic [DATA_WIDTH-1:0] rdata_q;

    // Read samples the array before this edge's write lands.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < NUM_NEURONS; c++) begin
                for (int i = 0; i <= NUM_WEIGHTS; i++) begin
                    mem_q[c][i] <= '0;
                end
            end
            rdata_q <= '0;
        end else begin
            if (we) begin
                mem_q[wch][widx] <= wdata;
            end
            if (re) begin
                rdata_q <= mem_q[rch][ridx];
            end
        end
    end

    assign rdata = rdata_q;

`ifdef WBANK_PARITY_EN
    logic par_q [NUM_NEURONS][NUM_WEIGHTS+1];
    logic rerr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < NUM_NEURONS; c++) begin
                for (int i = 0; i <= NUM_WEIGHTS; i++) begin
                    par_q[c][i] <= 1'b0;
                end
            end
            rerr_q <= 1'b0;
        end else begin
            if (we) begin
                par_q[wch][widx] <= ^wdata;
            end
            if (re) begin
                rerr_q <= ^{mem_q[rch][ridx], par_q[rch][ridx]};
            end
        end
    end

    assign rerr = rerr_q;
`endif

endmodule

// File: rtl/w_bank_stream.sv
// Runtime-loadable weight bank streaming one channel (weights, then bias)
// over valid/ready. Ports: clk, rst; wr_* load port + wr_err; start/start_ch
// + start_err; busy; m_valid/m_ready/m_data/m_idx/m_last; done.
// Optional WBANK_PARITY_EN adds sticky par_err.
module w_bank_stream
    import wbank_pkg::*;
#(
    parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
    parameter int NUM_WEIGHTS = 16,
    parameter int NUM_NEURONS = 4,
    parameter int CH_W        = ch_w_f(NUM_NEURONS),
    parameter int IDX_W       = idx_w_f(NUM_WEIGHTS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [CH_W-1:0]       wr_ch,
    input  logic [IDX_W-1:0]      wr_idx,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_err,
    input  logic                  start,
    input  logic [CH_W-1:0]       start_ch,
    output logic                  start_err,
    output logic                  busy,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic [IDX_W-1:0]      m_idx,
    output logic                  m_last,
`ifdef WBANK_PARITY_EN
    output logic                  par_err,
`endif
    output logic                  done
);

    localparam logic [CH_W:0]    NN_C     = (CH_W+1)'(NUM_NEURONS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WEIGHTS);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CH_W-1:0]  ch_q, ch_d;
    logic             valid_q, valid_d;
    logic             done_q, done_d;
    logic             wr_err_q, wr_err_d;
    logic             start_err_q, start_err_d;

    logic             hs, wr_ok, start_ok;
    logic             rd_en;
    logic [CH_W-1:0]  rd_ch;
    logic [IDX_W-1:0] rd_idx;

    assign hs = valid_q & m_ready;

    assign wr_ok = wr_en && (state_q == ST_IDLE)
                && ({1'b0, wr_ch} < NN_C) && (wr_idx <= LAST_IDX);

    assign start_ok = start && (state_q == ST_IDLE)
                   && ({1'b0, start_ch} < NN_C);

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        ch_d        = ch_q;
        valid_d     = valid_q;
        done_d      = 1'b0;
        rd_en       = 1'b0;
        rd_ch       = ch_q;
        rd_idx      = idx_q;
        wr_err_d    = wr_en & ~wr_ok;
        start_err_d = start & ~start_ok;
        unique case (state_q)
            ST_IDLE: begin
                if (start_ok) begin
                    state_d = ST_STREAM;
                    valid_d = 1'b1;
                    idx_d   = '0;
                    ch_d    = start_ch;
                    rd_en   = 1'b1;
                    rd_ch   = start_ch;
                    rd_idx  = '0;
                end
            end
            ST_STREAM: begin
                if (hs) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_IDLE;
                        valid_d = 1'b0;
                        idx_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        idx_d  = idx_q + IDX_W'(1);
                        rd_en  = 1'b1;
                        rd_idx = idx_q + IDX_W'(1);
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            ch_q        <= '0;
            valid_q     <= 1'b0;
            done_q      <= 1'b0;
            wr_err_q    <= 1'b0;
            start_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            ch_q        <= ch_d;
            valid_q     <= valid_d;
            done_q      <= done_d;
            wr_err_q    <= wr_err_d;
            start_err_q <= start_err_d;
        end
    end

`ifdef WBANK_PARITY_EN
    logic rd_err;
    logic par_sticky_q, par_sticky_d;

    // Sticky across the rest of the stream; an accepted start clears it.
    always_comb begin
        par_sticky_d = par_sticky_q | (valid_q & rd_err);
        if (start_ok) begin
            par_sticky_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            par_sticky_q <= 1'b0;
        end else begin
            par_sticky_q <= par_sticky_d;
        end
    end

    assign par_err = par_sticky_q | (valid_q & rd_err);
`endif

    wbank_regfile #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_WEIGHTS(NUM_WEIGHTS),
        .NUM_NEURONS(NUM_NEURONS),
        .CH_W       (CH_W),
        .IDX_W      (IDX_W)
    ) u_rf (
        .clk  (clk),
        .rst  (rst),
        .we   (wr_ok),
        .wch  (wr_ch),
        .widx (wr_idx),
        .wdata(wr_data),
        .re   (rd_en),
        .rch  (rd_ch),
        .ridx (rd_idx),
`ifdef WBANK_PARITY_EN
        .rerr (rd_err),
`endif
        .rdata(m_data)
    );

    assign m_valid   = valid_q;
    assign m_idx     = idx_q;
    assign m_last    = (idx_q == LAST_IDX);
    assign busy      = (state_q == ST_STREAM);
    assign done      = done_q;
    assign wr_err    = wr_err_q;
    assign start_err = start_err_q;

endmodule
